// File: rtl/vend_pkg.sv
package vend_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE
  } vend_state_e;

  localparam int unsigned DEF_NICKEL_VAL  = 1;
  localparam int unsigned DEF_DIME_VAL    = 2;
  localparam int unsigned DEF_QUARTER_VAL = 5;

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Greedy dime/nickel change serializer over a valid/ready handshake.
// Ports: i_load/i_amount start a dispense; o_ret_valid/o_ret_dime present a
// coin until i_ret_ready; o_done flags the handshake of the last coin.
module vend_change_dispenser #(
  parameter int unsigned AMT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [AMT_W-1:0] i_amount,
  input  logic             i_ret_ready,
  output logic             o_ret_valid,
  output logic             o_ret_dime,
  output logic             o_done
);

  logic [AMT_W-1:0] remaining_q;
  logic [AMT_W-1:0] step;
  logic [AMT_W-1:0] rem_after;

  always_comb begin
    step      = o_ret_dime ? AMT_W'(2) : AMT_W'(1);
    rem_after = remaining_q - step;
    o_done    = o_ret_valid && i_ret_ready && (rem_after == '0);
  end

  // Valid drops for one cycle after each accepted coin, so the next coin is
  // presented no sooner than the cycle after the handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      remaining_q <= '0;
      o_ret_valid <= 1'b0;
      o_ret_dime  <= 1'b0;
    end else if (i_load) begin
      remaining_q <= i_amount;
      o_ret_valid <= (i_amount != '0);
      o_ret_dime  <= (i_amount > AMT_W'(1));
    end else if (o_ret_valid) begin
      if (i_ret_ready) begin
        remaining_q <= rem_after;
        o_ret_valid <= 1'b0;
        o_ret_dime  <= 1'b0;
      end
    end else if (remaining_q != '0) begin
      o_ret_valid <= 1'b1;
      o_ret_dime  <= (remaining_q > AMT_W'(1));
    end
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised single-product vending controller: credit FSM, overflow
// rejection, cancel/refund, and coin-by-coin change return.
// Ports: coin inputs i_nickle/i_dime/i_quarter, i_cancel; vend pulse o_soda
// with o_change total; o_credit, o_busy, o_coin_reject; change return via
// o_ret_valid/o_ret_dime/i_ret_ready.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter  int unsigned PRICE       = 4,
  parameter  int unsigned MAX_CREDIT  = 11,
  parameter  int unsigned NICKEL_VAL  = DEF_NICKEL_VAL,
  parameter  int unsigned DIME_VAL    = DEF_DIME_VAL,
  parameter  int unsigned QUARTER_VAL = DEF_QUARTER_VAL,
  localparam int unsigned CREDIT_W    = $clog2(MAX_CREDIT + 1),
  localparam int unsigned CHANGE_W    =
    umax($clog2(umax(MAX_CREDIT - PRICE, PRICE - 1) + 1), 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_nickle,
  input  logic                i_dime,
  input  logic                i_quarter,
  input  logic                i_cancel,
  output logic                o_soda,
  output logic [CHANGE_W-1:0] o_change,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy,
  output logic                o_coin_reject,
  output logic                o_ret_valid,
  output logic                o_ret_dime,
  input  logic                i_ret_ready
);

  localparam int unsigned ACC_W =
    $clog2(MAX_CREDIT + NICKEL_VAL + DIME_VAL + QUARTER_VAL + 1);
  // A refund with same-cycle coins can exceed the vend change range; such a
  // batch is refused so the refund total always fits o_change.
  localparam int unsigned REFUND_MAX = umin(MAX_CREDIT, (2 ** CHANGE_W) - 1);

  vend_state_e state_q, state_d;

  logic [ACC_W-1:0]    batch;
  logic [ACC_W-1:0]    total;
  logic                coin_any;
  logic [CREDIT_W-1:0] credit_d;
  logic                soda_d;
  logic [CHANGE_W-1:0] change_d;
  logic                reject_d;
  logic                load;
  logic [CHANGE_W-1:0] load_amt;
  logic                disp_done;

  always_comb begin
    batch = '0;
    if (i_nickle)  batch = batch + ACC_W'(NICKEL_VAL);
    if (i_dime)    batch = batch + ACC_W'(DIME_VAL);
    if (i_quarter) batch = batch + ACC_W'(QUARTER_VAL);
    total    = ACC_W'(o_credit) + batch;
    coin_any = i_nickle | i_dime | i_quarter;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = o_credit;
    soda_d   = 1'b0;
    change_d = '0;
    reject_d = 1'b0;
    load     = 1'b0;
    load_amt = '0;

    unique case (state_q)
      ST_COLLECT: begin
        if (i_cancel) begin
          if (total <= ACC_W'(REFUND_MAX)) begin
            load_amt = CHANGE_W'(total);
          end else begin
            reject_d = coin_any;
            load_amt = CHANGE_W'(o_credit);
          end
          if (load_amt != '0) begin
            change_d = load_amt;
            load     = 1'b1;
            credit_d = '0;
            state_d  = ST_CHANGE;
          end
        end else if (total > ACC_W'(MAX_CREDIT)) begin
          reject_d = 1'b1;
        end else if (total >= ACC_W'(PRICE)) begin
          soda_d   = 1'b1;
          change_d = CHANGE_W'(total - ACC_W'(PRICE));
          credit_d = '0;
          state_d  = ST_VEND;
        end else begin
          credit_d = CREDIT_W'(total);
        end
      end

      ST_VEND: begin
        reject_d = coin_any;
        if (o_change != '0) begin
          load     = 1'b1;
          load_amt = o_change;
          state_d  = ST_CHANGE;
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_CHANGE: begin
        reject_d = coin_any;
        if (disp_done) state_d = ST_COLLECT;
      end

      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ST_COLLECT;
      o_credit      <= '0;
      o_soda        <= 1'b0;
      o_change      <= '0;
      o_coin_reject <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      o_credit      <= credit_d;
      o_soda        <= soda_d;
      o_change      <= change_d;
      o_coin_reject <= reject_d;
      o_busy        <= (state_d != ST_COLLECT);
    end
  end

  vend_change_dispenser #(
    .AMT_W(CHANGE_W)
  ) u_dispenser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (load),
    .i_amount   (load_amt),
    .i_ret_ready(i_ret_ready),
    .o_ret_valid(o_ret_valid),
    .o_ret_dime (o_ret_dime),
    .o_done     (disp_done)
  );

endmodule
